// File: rtl/boot_rom_pkg.sv
// Shared constants and request bundle for the boot ROM arbiter.
// Window base, ROM depth and word-address width live here.
package boot_rom_pkg;

   localparam logic [31:0] BOOT_ROM_BASE  = 32'h0000_8000;
   localparam int          BOOT_ROM_DEPTH = 548;
   localparam int          BOOT_ROM_AW    = 10;

   typedef struct packed {
      logic        req;
      logic [31:0] addr;
   } rom_req_t;

endpackage

// File: rtl/boot_rom_arbiter_rr_arb2.sv
// Two-way round-robin arbiter.
// Lone requester wins; under contention the pointer picks the winner.
module rr_arb2 (
   input  logic       CLK,
   input  logic       RST,
   input  logic [1:0] req,
   output logic [1:0] gnt
);

   logic rr_ptr;

   // Combinational grant; nothing is granted while in reset.
   always_comb begin
      gnt = 2'b00;
      if (!RST) begin
         priority case (1'b1)
            req[0] && req[1]: gnt = rr_ptr ? 2'b10 : 2'b01;
            req[0]:           gnt = 2'b01;
            req[1]:           gnt = 2'b10;
            default:          gnt = 2'b00;
         endcase
      end
   end

   // After a grant, favour the master that was not granted.
   always_ff @(posedge CLK) begin
      if (RST) begin
         rr_ptr <= 1'b0;
      end else if (gnt[0]) begin
         rr_ptr <= 1'b1;
      end else if (gnt[1]) begin
         rr_ptr <= 1'b0;
      end
   end

endmodule

// File: rtl/boot_rom_arbiter.sv
// Two-master arbiter in front of the single-port boot ROM.
// Decodes the ROM window, drives csn/address, returns data next cycle.
module boot_rom_arbiter
   import boot_rom_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = BOOT_ROM_BASE,
   parameter int          ROM_DEPTH = BOOT_ROM_DEPTH,
   parameter int          ROM_AW    = BOOT_ROM_AW
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              m0_req_i,
   input  logic [31:0]       m0_addr_i,
   output logic              m0_gnt_o,
   output logic              m0_rvalid_o,
   output logic [31:0]       m0_rdata_o,
   output logic              m0_err_o,
   input  logic              m1_req_i,
   input  logic [31:0]       m1_addr_i,
   output logic              m1_gnt_o,
   output logic              m1_rvalid_o,
   output logic [31:0]       m1_rdata_o,
   output logic              m1_err_o,
   output logic              rom_csn_o,
   output logic [ROM_AW-1:0] rom_addr_o,
   input  logic [31:0]       rom_rdata_i
);

   localparam logic [ROM_AW:0] DEPTH_W = (ROM_AW+1)'(ROM_DEPTH);

   rom_req_t          mreq [2];
   logic [1:0]        req;
   logic [1:0]        gnt;
   logic [1:0]        hit;
   logic [ROM_AW-1:0] idx  [2];

   logic              any_gnt;
   logic              sel_id;
   logic              sel_hit;
   logic [ROM_AW-1:0] sel_idx;
   logic [ROM_AW-1:0] addr_q;

   logic              resp_valid;
   logic              resp_id;
   logic              resp_err;
   logic              rsp_live;

   // Bundle the master ports so decode can loop over them.
   always_comb begin
      mreq[0] = '{req: m0_req_i, addr: m0_addr_i};
      mreq[1] = '{req: m1_req_i, addr: m1_addr_i};
   end

   // Window compare on the upper bits plus a depth check on the word index.
   always_comb begin
      for (int i = 0; i < 2; i++) begin
         req[i] = mreq[i].req;
         idx[i] = mreq[i].addr[ROM_AW+1:2];
         hit[i] = (mreq[i].addr[31:12] == BASE_ADDR[31:12])
               && ({1'b0, idx[i]} < DEPTH_W);
      end
   end

   rr_arb2 u_arb (
      .CLK (CLK),
      .RST (RST),
      .req (req),
      .gnt (gnt)
   );

   assign any_gnt    = |gnt;
   assign sel_id     = gnt[1];
   assign sel_hit    = hit[sel_id];
   assign sel_idx    = idx[sel_id];

   assign m0_gnt_o   = gnt[0];
   assign m1_gnt_o   = gnt[1];

   // Only a granted hit touches the ROM; otherwise the address holds.
   assign rom_csn_o  = ~(any_gnt & sel_hit);
   assign rom_addr_o = rom_csn_o ? addr_q : sel_idx;

   // Capture the grant for the one-cycle response and remember the address.
   always_ff @(posedge CLK) begin
      if (RST) begin
         addr_q     <= '0;
         resp_valid <= 1'b0;
         resp_id    <= 1'b0;
         resp_err   <= 1'b0;
      end else begin
         resp_valid <= any_gnt;
         resp_id    <= sel_id;
         resp_err   <= ~sel_hit;
         if (!rom_csn_o) begin
            addr_q <= sel_idx;
         end
      end
   end

   // A response in flight when reset arrives is dropped.
   assign rsp_live    = resp_valid & ~RST;

   assign m0_rvalid_o = rsp_live & ~resp_id;
   assign m1_rvalid_o = rsp_live & resp_id;
   assign m0_err_o    = m0_rvalid_o & resp_err;
   assign m1_err_o    = m1_rvalid_o & resp_err;
   assign m0_rdata_o  = (m0_rvalid_o & ~resp_err) ? rom_rdata_i : '0;
   assign m1_rdata_o  = (m1_rvalid_o & ~resp_err) ? rom_rdata_i : '0;

endmodule

// File: doc/boot_rom_arbiter.md
Name: boot_rom_arbiter

Overview:
Two-master arbiter in front of the single-port boot ROM. Master 0 is the core instruction-fetch port; master 1 is the data/debug port.
Provides a req/gnt/rvalid handshake per master, performs address decode and range checking, and drives the ROM chip-select and word address.
Arbitration is round-robin. Response latency is fixed at one cycle, matching the ROM's registered-address read.

Parameters:
BASE_ADDR, 32'h0000_8000, byte base address of the boot ROM window (4 KiB window, bits [31:12] compared)
ROM_DEPTH, 548, number of valid 32-bit words in the ROM
ROM_AW, 10, ROM word-address width

Ports:
CLK  input  1  system clock
RST  input  1  reset; one clock; reset is synchronous and active-high
m0_req_i  input  1  master 0 request
m0_addr_i  input  32  master 0 byte address
m0_gnt_o  output  1  master 0 grant (same cycle as accepted request)
m0_rvalid_o  output  1  master 0 response valid
m0_rdata_o  output  32  master 0 read data
m0_err_o  output  1  master 0 error, qualified by m0_rvalid_o
m1_req_i, m1_addr_i, m1_gnt_o, m1_rvalid_o, m1_rdata_o, m1_err_o  as master 0, for master 1
rom_csn_o  output  1  ROM chip select, active low
rom_addr_o  output  ROM_AW  ROM word address
rom_rdata_i  input  32  ROM data; valid the cycle after a csn-low edge

Behaviour:
- Decode
  - hit = (addr[31:12] == BASE_ADDR[31:12]) && (addr[11:2] < ROM_DEPTH).
  - Word index = addr[11:2]; addr[1:0] are ignored (word read always).
- Arbitration (combinational, per cycle)
  - Only one request: it is granted.
  - Both requesting: the master selected by rr_ptr is granted.
  - gnt_o is asserted only for the selected master, and only while RST=0.
  - After any grant, rr_ptr <= index of the master not granted, giving strict alternation under contention.
  - Idle cycles leave rr_ptr unchanged.
  - rr_ptr resets to 0 (master 0 first).
- ROM drive
  - On a granted hit: rom_csn_o=0, rom_addr_o=word index.
  - Otherwise (no grant, granted miss, or RST=1): rom_csn_o=1 and rom_addr_o holds its last value (registered mux select is acceptable).
- Response pipeline (registers)
  - resp_valid, resp_id and resp_err capture the grant every cycle.
  - In the cycle after a grant, rvalid_o of resp_id is 1.
  - rdata_o = rom_rdata_i on a hit; rdata_o = 32'h0 and err_o=1 on a miss.
  - Only the responding master sees rvalid=1; the other master's rdata_o is 32'h0.
- Throughput and fairness
  - One access per cycle, back-to-back, with no bubble.
  - A continuously requesting master is granted within 2 cycles.
- Simultaneous events
  - A new grant in the same cycle as a pending response is legal (pipelined). The response still goes to the previous resp_id.
- Reset values: all gnt/rvalid/err=0, rdata=0, rom_csn_o=1, rom_addr_o=0, rr_ptr=0, resp_valid=0.
- Reset mid-operation: an in-flight response is discarded (no rvalid after RST); requests are ignored while RST=1.
- Masters must hold req/addr stable until gnt; the arbiter does not check this.

Decomposition:
- Shared package boot_rom_pkg holds: BOOT_ROM_BASE, BOOT_ROM_DEPTH, BOOT_ROM_AW, and a typedef struct rom_req_t {req, addr}.
- One natural sub-module: rr_arb2, the two-way round-robin arbiter (req[1:0] -> gnt[1:0], internal pointer, update on grant).

Test Plan:
- m0 only, addr 0x0000_8000 -> m0_gnt same cycle, rom_addr=0, next cycle m0_rvalid=1, m0_rdata=0x00000013, err=0.
- m1 only, addr 0x0000_807C -> rom_addr=31, next cycle m1_rdata=0x0100006F; m0_rvalid stays 0.
- Both request continuously, addr 0x8000/0x8090, for 6 cycles from reset -> grants m0,m1,m0,m1,m0,m1; responses alternate 0x00000013 / 0x00000093.
- m0 addr 0x0000_8890 (index 548) and m1 addr 0x1000_0000 -> each gnt, rom_csn stays 1, next cycle rvalid=1, err=1, rdata=0.
- Grant m0 at cycle N, assert RST at cycle N+1 -> no rvalid at N+1 or later; after release, the first contended grant goes to m0.
- Back-to-back m0 reads of indices 0..35 -> 36 consecutive rvalid cycles, no bubble, data matches the boot image.
